// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared read-FSM type and BRAM constants for frame_buffer_scheduler.
// BANK_BITS is 1 when DOUBLE_BUFFER_EN is defined, else 0.
package frame_buffer_pkg;
    typedef enum logic [1:0] {IDLE, READING, FLUSH} rd_state_t;
    localparam int BRAM_LATENCY = 2;
`ifdef DOUBLE_BUFFER_EN
    localparam int BANK_BITS = 1;
`else
    localparam int BANK_BITS = 0;
`endif
endpackage

// File: rtl/frame_buffer_scheduler_raster_addr_gen.sv
// raster_addr_gen: raster h/v/linear position counter; clear forces position 0 before any step.
module raster_addr_gen #(
    parameter int HCOUNT = 160,
    parameter int VCOUNT = 90,
    localparam int NPIX = HCOUNT * VCOUNT,
    localparam int HW = $clog2(HCOUNT),
    localparam int VW = $clog2(VCOUNT),
    localparam int LW = $clog2(NPIX)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          step_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic [LW-1:0] lin_o,
    output logic          last_o
);
    logic [HW-1:0] h_q, h_b, h_d;
    logic [VW-1:0] v_q, v_b, v_d;
    logic [LW-1:0] l_q, l_b, l_d;
    logic          h_wrap;

    assign h_b    = clear_i ? '0 : h_q;
    assign v_b    = clear_i ? '0 : v_q;
    assign l_b    = clear_i ? '0 : l_q;
    assign h_wrap = h_b == HW'(HCOUNT - 1);
    assign h_d    = !step_i ? h_b : h_wrap ? '0 : h_b + 1'b1;
    assign v_d    = !(step_i && h_wrap) ? v_b : (v_b == VW'(VCOUNT - 1)) ? '0 : v_b + 1'b1;
    assign l_d    = !step_i ? l_b : (l_b == LW'(NPIX - 1)) ? '0 : l_b + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
            l_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            l_q <= l_d;
        end
    end

    assign h_o    = h_q;
    assign v_o    = v_q;
    assign lin_o  = l_q;
    assign last_o = l_q == LW'(NPIX - 1);
endmodule

// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: arbitrates one single-port frame BRAM between camera writes and full-frame reads.
// Define DOUBLE_BUFFER_EN to add a bank bit so reads never see the frame currently being written.
module frame_buffer_scheduler
    import frame_buffer_pkg::*;
#(
    parameter int HCOUNT = 160,
    parameter int VCOUNT = 90,
    parameter int WIDTH = 8,
    localparam int NPIX = HCOUNT * VCOUNT,
    localparam int LW = $clog2(NPIX),
    localparam int AW = LW + BANK_BITS,
    localparam int HW = $clog2(HCOUNT),
    localparam int VW = $clog2(VCOUNT)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             wr_valid_in,
    input  logic             wr_sof_in,
    input  logic [WIDTH-1:0] wr_data_in,
    output logic             wr_frame_done_out,
    input  logic             rd_start_in,
    input  logic             rd_ready_in,
    output logic             rd_busy_out,
    output logic             rd_valid_out,
    output logic [WIDTH-1:0] rd_data_out,
    output logic [HW-1:0]    rd_hcount_out,
    output logic [VW-1:0]    rd_vcount_out,
    output logic             rd_done_out,
    output logic [AW-1:0]    bram_addr_out,
    output logic             bram_we_out,
    output logic [WIDTH-1:0] bram_din_out,
    input  logic [WIDTH-1:0] bram_dout_in
);
    logic          wr_acc, wr_last, rd_issue, rd_clear, rd_last;
    logic [LW-1:0] wr_lin, wr_addr, rd_lin;
    logic [HW-1:0] wr_h_unused, rd_h, h1_q, h2_q;
    logic [VW-1:0] wr_v_unused, rd_v, v1_q, v2_q;
    logic [1:0]    vld_q, flush_q;
    logic          busy_q, done_q;
    rd_state_t     state_q;

    // A camera pixel cannot be stalled, so a write always takes the port.
    assign wr_acc            = wr_valid_in & ~rst_in;
    assign wr_addr           = wr_sof_in ? '0 : wr_lin;
    assign wr_frame_done_out = wr_acc & ~wr_sof_in & wr_last;
    assign rd_issue          = ~rst_in & ~wr_valid_in & rd_ready_in & (state_q == READING);
    assign rd_clear          = (state_q == IDLE) & rd_start_in;

    raster_addr_gen #(.HCOUNT(HCOUNT), .VCOUNT(VCOUNT)) u_wr_gen (
        .clk_i(clk_in), .rst_i(rst_in), .clear_i(wr_sof_in & wr_valid_in), .step_i(wr_acc),
        .h_o(wr_h_unused), .v_o(wr_v_unused), .lin_o(wr_lin), .last_o(wr_last)
    );

    raster_addr_gen #(.HCOUNT(HCOUNT), .VCOUNT(VCOUNT)) u_rd_gen (
        .clk_i(clk_in), .rst_i(rst_in), .clear_i(rd_clear), .step_i(rd_issue),
        .h_o(rd_h), .v_o(rd_v), .lin_o(rd_lin), .last_o(rd_last)
    );

`ifdef DOUBLE_BUFFER_EN
    logic bank_q;
    // Swap banks only between read frames so a frame read is never torn.
    always_ff @(posedge clk_in) begin
        if (rst_in) bank_q <= 1'b0;
        else if (wr_frame_done_out && state_q == IDLE) bank_q <= ~bank_q;
    end
    assign bram_addr_out = wr_acc ? {bank_q, wr_addr} : rd_issue ? {~bank_q, rd_lin} : '0;
`else
    assign bram_addr_out = wr_acc ? wr_addr : rd_issue ? rd_lin : '0;
`endif
    assign bram_we_out  = wr_acc;
    assign bram_din_out = wr_acc ? wr_data_in : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= '0;
            vld_q   <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
        end else begin
            vld_q  <= {vld_q[0], rd_issue};
            h1_q   <= rd_h;
            h2_q   <= h1_q;
            v1_q   <= rd_v;
            v2_q   <= v1_q;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (rd_start_in) begin
                    state_q <= READING;
                    busy_q  <= 1'b1;
                end
                READING: if (rd_issue && rd_last) begin
                    state_q <= FLUSH;
                    flush_q <= '0;
                end
                FLUSH: if (flush_q == 2'(BRAM_LATENCY - 2)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else flush_q <= flush_q + 2'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_busy_out   = busy_q;
    assign rd_done_out   = done_q;
    assign rd_valid_out  = vld_q[1];
    assign rd_hcount_out = h2_q;
    assign rd_vcount_out = v2_q;
    assign rd_data_out   = vld_q[1] ? bram_dout_in : '0;
endmodule
